// File: rtl/fixed_point_mac_accumulator.sv
// Accumulates a stream of sign-magnitude products plus a bias in a wider
// two's-complement register and returns a saturated sign-magnitude result.
module fixed_point_mac_accumulator #(
  parameter int BITSIZE = 24,
  parameter int GUARD   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIZE-1:0] in_data,
  input  logic               in_last,
  input  logic [BITSIZE-1:0] bias,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] out_data,
  output logic               out_sat,
  output logic [CNT_W-1:0]   out_count
);

  localparam int ACC_W = BITSIZE + GUARD;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [BITSIZE-1:0]   out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;

  logic                 beat_fire;
  logic [ACC_W-1:0]     sum_base;
  logic [ACC_W-1:0]     sum_new;
  logic [CNT_W-1:0]     cnt_new;
  logic [BITSIZE:0]     sm_result;

  // Sign-magnitude to two's complement; -0 maps to 0 naturally.
  function automatic logic [ACC_W-1:0] to_tc(input logic [BITSIZE-1:0] v);
    logic [ACC_W-1:0] m;
    m = {{(GUARD+1){1'b0}}, v[BITSIZE-2:0]};
    return v[BITSIZE-1] ? (~m + 1'b1) : m;
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  // Returns {sat, sign, magnitude}; the most negative sum still has a valid
  // unsigned magnitude after negation, so the overflow test is a plain OR.
  function automatic logic [BITSIZE:0] to_sm(input logic [ACC_W-1:0] s);
    logic [ACC_W-1:0] mag;
    logic             over;
    mag  = s[ACC_W-1] ? (~s + 1'b1) : s;
    over = |mag[ACC_W-1:BITSIZE-1];
    if (over)
      return {1'b1, s[ACC_W-1], {(BITSIZE-1){1'b1}}};
    return {1'b0, s[ACC_W-1], mag[BITSIZE-2:0]};
  endfunction

  assign in_ready  = (state_q != DONE);
  assign beat_fire = in_valid && in_ready;

  assign sum_base  = (state_q == IDLE) ? to_tc(bias) : acc_q;
  assign sum_new   = sat_add(sum_base, to_tc(in_data));
  assign cnt_new   = (state_q == IDLE) ? CNT_W'(1)
                   : ((cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1);
  assign sm_result = to_sm(sum_new);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat_fire) begin
          acc_d = sum_new;
          cnt_d = cnt_new;
          if (in_last) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_sat_d   = sm_result[BITSIZE];
            out_data_d  = sm_result[BITSIZE-1:0];
            out_count_d = cnt_new;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_fixed_point_mac_accumulator.sv
// Directed bench for fixed_point_mac_accumulator with hand-computed results.
module tb_fixed_point_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_last;
  logic [23:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_sat;
  logic [7:0]  out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_point_mac_accumulator #(.BITSIZE(24), .GUARD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted beat; inputs change #1 after the edge, outputs are read there too.
  task automatic beat(input logic [23:0] d, input logic l, input logic [23:0] b);
    chk("beat_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    bias     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic result(input string tag, input logic [23:0] d, input logic s,
                        input logic [7:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_sat"},   32'(out_sat),   32'(s));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    $display("result %s: data=%06h sat=%0d count=%0d", tag, out_data, out_sat, out_count);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_hs_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    bias = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_sat",   32'(out_sat),   32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);

    // +1.0 bias, +0.5 -0.5 +2.0; bias changes later must be ignored
    beat(24'h040000, 1'b0, 24'h080000);
    beat(24'h840000, 1'b0, 24'h7FFFFF);
    beat(24'h100000, 1'b1, 24'h7FFFFF);
    result("normal", 24'h180000, 1'b0, 8'd3);
    chk("normal_in_ready", 32'(in_ready), 32'd0);

    // Backpressure with a competing beat offered
    in_valid = 1'b1; in_data = 24'h7FFFFF; in_last = 1'b1; bias = 24'h7FFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      result("bp", 24'h180000, 1'b0, 8'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_ready", 32'(in_ready),  32'd1);
    chk("bp_hs_hold",  32'(out_data),  32'h180000);
    chk("bp_hs_cnt",   32'(out_count), 32'd3);

    // Fresh vector after backpressure: +1.0 + 0.5
    beat(24'h040000, 1'b1, 24'h080000);
    result("fresh", 24'h0C0000, 1'b0, 8'd1);
    handshake("fresh");

    beat(24'h7FFFFF, 1'b0, 24'h000000);
    beat(24'h7FFFFF, 1'b1, 24'h000000);
    result("possat", 24'h7FFFFF, 1'b1, 8'd2);
    handshake("possat");

    beat(24'hFFFFFF, 1'b1, 24'hFFFFFF);
    result("negsat", 24'hFFFFFF, 1'b1, 8'd1);
    handshake("negsat");

    beat(24'h040000, 1'b0, 24'h800000);
    beat(24'h840000, 1'b1, 24'h800000);
    result("zero", 24'h000000, 1'b0, 8'd2);
    handshake("zero");

    // -1.0 - 0.5 = -1.5
    beat(24'h840000, 1'b1, 24'h880000);
    result("neg", 24'h8C0000, 1'b0, 8'd1);
    handshake("neg");

    // Beat counter saturates at 255
    for (int i = 0; i < 299; i++) beat(24'h000001, 1'b0, 24'h000000);
    beat(24'h000001, 1'b1, 24'h000000);
    result("cntsat", 24'h00012C, 1'b0, 8'd255);
    handshake("cntsat");

    // Reset mid-vector discards partial sum and count
    beat(24'h080000, 1'b0, 24'h080000);
    beat(24'h080000, 1'b0, 24'h080000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  32'(out_data),  32'h0);
    beat(24'h080000, 1'b1, 24'h000000);
    result("midrst", 24'h080000, 1'b0, 8'd1);
    handshake("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
